shared_acc_arbiter: RTL and testbench

Round-robin arbiter that shares a single WIDTH-bit accumulator register between NREQ requesters. Each requester issues load, add, subtract or read beats. A requester holds ownership for a burst of up to MAX_BURST beats before the grant rotates. The block sits between tick-style register-update logic and the one shared state register, so that only one writer touches that register per cycle.

---
 rtl/shared_acc_arbiter.sv | 132 +++++++++++++
 tb/tb_shared_acc_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_acc_arbiter.sv
// Round-robin arbiter that gives NREQ requesters bursts of access to a single
// shared WIDTH-bit accumulator. Each beat is a load, add, sub or read. One
// IDLE cycle separates consecutive ownerships.
module shared_acc_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] wdata,
  input  logic [NREQ-1:0]       last,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rdata,
  output logic [WIDTH-1:0]      acc,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [3:0]      beat_cnt;

  logic [IW-1:0]   pick;
  logic [IW-1:0]   next_ptr;
  logic [1:0]      own_op;
  logic [WIDTH-1:0] own_wdata;
  logic            own_req;
  logic            own_last;
  logic            last_beat;

  // Accumulator update for one beat; add/sub wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] acc_next(input logic [1:0]       o,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (o)
      OP_LOAD: r = d;
      OP_ADD:  r = a + d;
      OP_SUB:  r = a - d;
      default: r = a;
    endcase
    return r;
  endfunction

  // First requester at or after p, scanning upward modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
    logic [IW-1:0]   sel;
    logic [NREQ-1:0] sh;
    int              idx;
    sel = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      sh  = r >> idx;
      if (sh[0]) sel = IW'(idx);
    end
    return sel;
  endfunction

  // Owner's lane of the request bundle, next grant candidate and release pointer.
  always_comb begin
    own_op    = 2'(op >> (2 * int'(owner)));
    own_wdata = WIDTH'(wdata >> (WIDTH * int'(owner)));
    own_req   = req[owner];
    own_last  = last[owner];
    last_beat = own_last || (beat_cnt == 4'(MAX_BURST - 1));
    next_ptr  = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    pick      = rr_pick(req, rr_ptr);
  end

  // Arbitration FSM with the accumulator and all outputs registered.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= OWN;
            owner    <= pick;
            gnt      <= NREQ'(1) << pick;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        OWN: begin
          if (own_req) begin
            acc      <= acc_next(own_op, acc, own_wdata);
            rdata    <= acc;
            ack      <= NREQ'(1) << owner;
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state  <= IDLE;
              gnt    <= '0;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
            end
          end else begin
            // Owner walked away: release without executing a beat.
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_acc_arbiter.sv
// Bench for shared_acc_arbiter: a cycle model built from plain integers is
// compared with the DUT every cycle, and directed scenarios add literal checks.
module tb_shared_acc_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  localparam logic [1:0] LD = 2'd0;
  localparam logic [1:0] AD = 2'd1;
  localparam logic [1:0] SB = 2'd2;
  localparam logic [1:0] RD = 2'd3;

  logic                  clock = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req   = '0;
  logic [2*NREQ-1:0]     op    = '0;
  logic [WIDTH*NREQ-1:0] wdata = '0;
  logic [NREQ-1:0]       last  = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      rdata;
  logic [WIDTH-1:0]      acc;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  shared_acc_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .rst_n(rst_n), .req(req), .op(op), .wdata(wdata),
    .last(last), .gnt(gnt), .ack(ack), .rdata(rdata), .acc(acc), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when nobody owns), accumulator as an int.
  int m_own   = -1;
  int m_acc   = 0;
  int m_rr    = 0;
  int m_cnt   = 0;
  int m_ack   = 0;
  int m_rdata = 0;
  int m_w, m_o;

  function automatic int bit_of(input logic [NREQ-1:0] v, input int i);
    return int'((v >> i) & NREQ'(1));
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_acc = 0; m_rr = 0; m_cnt = 0; m_ack = 0; m_rdata = 0;
    end else begin
      m_ack = 0;
      if (m_own < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (m_own < 0 && bit_of(req, (m_rr + k) % NREQ) == 1) begin
            m_own = (m_rr + k) % NREQ;
            m_cnt = 0;
          end
        end
      end else begin
        m_o = m_own;
        if (bit_of(req, m_o) == 1) begin
          m_rdata = m_acc;
          m_w = int'(wdata >> (WIDTH * m_o)) & 255;
          case (int'(op >> (2 * m_o)) & 3)
            0: m_acc = m_w;
            1: m_acc = (m_acc + m_w) % 256;
            2: m_acc = (m_acc - m_w + 256) % 256;
            default: ;
          endcase
          m_ack = 1 << m_o;
          m_cnt++;
          if (bit_of(last, m_o) == 1 || m_cnt == MAX_BURST) begin
            m_own = -1;
            m_rr  = (m_o + 1) % NREQ;
          end
        end else begin
          m_own = -1;
          m_rr  = (m_o + 1) % NREQ;
        end
      end
    end
  end

  // Every-cycle comparison against the model plus structural invariants.
  always @(negedge clock) begin
    chk("gnt", int'(gnt), (m_own < 0) ? 0 : (1 << m_own));
    chk("ack", int'(ack), m_ack);
    chk("acc", int'(acc), m_acc);
    chk("rdata", int'(rdata), m_rdata);
    chk("busy", int'(busy), (m_own < 0) ? 0 : 1);
    chk("busy_eq_or_gnt", int'(busy), int'(|gnt));
    chk("gnt_onehot0", int'($onehot0(gnt)), 1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input int r, input logic [1:0] o, input logic [7:0] d, input logic l);
    op    = (op & ~(8'(3) << (2 * r))) | (8'(o) << (2 * r));
    wdata = (wdata & ~(32'hFF << (8 * r))) | (32'(d) << (8 * r));
    last  = (last & ~(4'(1) << r)) | (4'(l) << r);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_ack", int'(ack), 0);

    // Single load/add burst by requester 0
    drive(0, LD, 8'h10, 1'b0);
    req = 4'b0001;
    step(1);
    chk("t1_gnt", int'(gnt), 1);
    chk("t1_busy", int'(busy), 1);
    step(1);
    chk("t1_ack1", int'(ack), 1);
    chk("t1_rdata1", int'(rdata), 8'h00);
    chk("t1_acc1", int'(acc), 8'h10);
    drive(0, AD, 8'h05, 1'b1);
    step(1);
    chk("t1_ack2", int'(ack), 1);
    chk("t1_rdata2", int'(rdata), 8'h10);
    chk("t1_acc2", int'(acc), 8'h15);
    chk("t1_busy_end", int'(busy), 0);
    req = 4'b0000;
    step(1);
    chk("t1_ack_clear", int'(ack), 0);

    // Wrap-around arithmetic and read-back
    drive(0, LD, 8'hF0, 1'b0);
    req = 4'b0001;
    step(1);
    chk("t2_gnt", int'(gnt), 1);
    step(1);
    chk("t2_load", int'(acc), 8'hF0);
    drive(0, AD, 8'h20, 1'b0);
    step(1);
    chk("t2_add_wrap", int'(acc), 8'h10);
    drive(0, SB, 8'h40, 1'b0);
    step(1);
    chk("t2_sub_wrap", int'(acc), 8'hD0);
    drive(0, RD, 8'h00, 1'b1);
    step(1);
    chk("t2_read_rdata", int'(rdata), 8'hD0);
    chk("t2_read_acc", int'(acc), 8'hD0);
    req = 4'b0000;
    step(1);

    // Round-robin fairness with everyone requesting single-beat bursts
    do_reset();
    for (int i = 0; i < NREQ; i++) drive(i, RD, 8'h00, 1'b1);
    req = 4'b1111;
    step(1);
    for (int g = 0; g < 5; g++) begin
      chk("t3_rr_gnt", int'(gnt), 1 << (g % 4));
      step(1);
      chk("t3_rr_idle", int'(gnt), 0);
      chk("t3_rr_ack", int'(ack), 1 << (g % 4));
      step(1);
    end
    req = 4'b0000;
    step(2);

    // After reset, lone requester 2 is granted
    do_reset();
    req = 4'b0100;
    step(1);
    chk("t3_only2", int'(gnt), 4'b0100);
    req = 4'b0000;
    step(2);

    // Forced release after MAX_BURST beats, then requester 3, then 1 again
    do_reset();
    drive(1, AD, 8'h01, 1'b0);
    drive(3, RD, 8'h00, 1'b1);
    req = 4'b1010;
    step(1);
    chk("t4_gnt1", int'(gnt), 4'b0010);
    for (int b = 0; b < MAX_BURST; b++) begin
      step(1);
      chk("t4_ack", int'(ack), 4'b0010);
    end
    chk("t4_released", int'(gnt), 0);
    chk("t4_acc", int'(acc), 4);
    step(1);
    chk("t4_gnt3", int'(gnt), 4'b1000);
    step(1);
    chk("t4_ack3", int'(ack), 4'b1000);
    step(1);
    chk("t4_regnt1", int'(gnt), 4'b0010);
    req = 4'b0000;
    step(2);

    // Abandon: owner 2 drops req mid-burst; pointer moves past 2
    drive(2, AD, 8'h07, 1'b0);
    req = 4'b0100;
    step(1);
    chk("t5_gnt2", int'(gnt), 4'b0100);
    step(1);
    chk("t5_acc_beat", int'(acc), 8'h0B);
    req = 4'b0000;
    step(1);
    chk("t5_no_ack", int'(ack), 0);
    chk("t5_acc_kept", int'(acc), 8'h0B);
    chk("t5_gnt_drop", int'(gnt), 0);
    req = 4'b0101;
    step(1);
    chk("t5_rr_past2", int'(gnt), 4'b0001);
    req = 4'b0000;
    step(2);

    // Asynchronous reset in the middle of an add burst
    drive(1, AD, 8'h03, 1'b0);
    req = 4'b0010;
    step(1);
    chk("t6_gnt", int'(gnt), 4'b0010);
    step(1);
    chk("t6_acc_beat", int'(acc), 8'h0E);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", int'(gnt), 0);
    chk("t6_rst_ack", int'(ack), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_acc", int'(acc), 0);
    step(2);
    chk("t6_held_acc", int'(acc), 0);
    chk("t6_held_gnt", int'(gnt), 0);
    req = 4'b1010;
    rst_n = 1'b1;
    step(1);
    chk("t6_first_gnt", int'(gnt), 4'b0010);
    req = 4'b0000;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
